// File: rtl/wishbone_master_slave.sv
// Wishbone B4 classic point-to-point subsystem.
// A req/gnt client port drives a single-transfer Wishbone master. The master is
// wired to a word-addressed register-file slave with byte-lane write enables.
// Internal bus signals are also driven out so the handshake can be observed.
//
// Master FSM
//   state | meaning
//   IDLE  | no bus cycle open; i_req is sampled here
//   BUSY  | CYC/STB asserted, waiting for the slave ACK
module wishbone_master_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = 16
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic                      i_req,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   input  logic                      i_we,
   output logic [DATA_WIDTH-1:0]     o_rdata,
   output logic                      o_gnt,
   output logic [ADDR_WIDTH-1:0]     o_ADDR,
   output logic [DATA_WIDTH-1:0]     o_DATA,
   output logic [DATA_WIDTH-1:0]     o_SDATA,
   output logic                      o_WE,
   output logic                      o_STB,
   output logic                      o_CYC,
   output logic                      o_ACK,
   output logic [DATA_WIDTH/8-1:0]   o_SEL
);

   localparam int SEL_W = DATA_WIDTH / 8;
   // A single-word memory still needs a one-bit index to keep slices legal.
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   adr_q;
   logic [DATA_WIDTH-1:0]   dat_q;
   logic                    we_q;
   logic [SEL_W-1:0]        sel_q;
   logic                    cyc_q;
   logic                    stb_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    gnt_q;

   logic                    ack_q;
   logic [DATA_WIDTH-1:0]   sdat_q;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic [IDX_W-1:0]        slv_idx;
   logic                    slv_access;

   // Upper address bits are dropped so accesses wrap around the memory.
   assign slv_idx    = adr_q[IDX_W-1:0];
   // Only the first cycle of a strobe is an access; ACK masks the second.
   assign slv_access = cyc_q & stb_q & ~ack_q;

   // Master: open one bus cycle per accepted request, close it on ACK.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         rdata_q <= '0;
         gnt_q   <= 1'b0;
      end else begin
         gnt_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req) begin
                  adr_q   <= i_addr;
                  dat_q   <= i_wdata;
                  we_q    <= i_we;
                  sel_q   <= '1;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cyc_q && stb_q && ack_q) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  gnt_q   <= 1'b1;
                  if (!we_q) begin
                     rdata_q <= sdat_q;
                  end
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Slave ACK: registered single-cycle pulse, never back-to-back.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= slv_access;
      end
   end

   // Slave storage: byte-lane writes and registered read data, on the ACK-raising edge.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         sdat_q <= '0;
         for (int w = 0; w < MEM_DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (slv_access) begin
         if (we_q) begin
            for (int k = 0; k < SEL_W; k++) begin
               if (sel_q[k]) begin
                  mem_q[slv_idx][8*k +: 8] <= dat_q[8*k +: 8];
               end
            end
         end else begin
            sdat_q <= mem_q[slv_idx];
         end
      end
   end

   assign o_rdata = rdata_q;
   assign o_gnt   = gnt_q;
   assign o_ADDR  = adr_q;
   assign o_DATA  = dat_q;
   assign o_SDATA = sdat_q;
   assign o_WE    = we_q;
   assign o_STB   = stb_q;
   assign o_CYC   = cyc_q;
   assign o_ACK   = ack_q;
   assign o_SEL   = sel_q;

endmodule

// File: tb/tb_wishbone_master_slave.sv
// Bench for wishbone_master_slave: vector table of single transfers with
// per-cycle handshake checks, plus a read-data scoreboard popped on o_gnt,
// and hand sequences for request hold and mid-cycle reset.
module tb_wishbone_master_slave;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MD = 16;

   logic          clk;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wdata;
   logic          i_we;
   logic [DW-1:0] o_rdata;
   logic          o_gnt;
   logic [AW-1:0] o_ADDR;
   logic [DW-1:0] o_DATA;
   logic [DW-1:0] o_SDATA;
   logic          o_WE;
   logic          o_STB;
   logic          o_CYC;
   logic          o_ACK;
   logic [DW/8-1:0] o_SEL;

   wishbone_master_slave #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MEM_DEPTH (MD)
   ) dut (
      .i_CLK  (clk),
      .i_RST  (rst),
      .i_req  (i_req),
      .i_addr (i_addr),
      .i_wdata(i_wdata),
      .i_we   (i_we),
      .o_rdata(o_rdata),
      .o_gnt  (o_gnt),
      .o_ADDR (o_ADDR),
      .o_DATA (o_DATA),
      .o_SDATA(o_SDATA),
      .o_WE   (o_WE),
      .o_STB  (o_STB),
      .o_CYC  (o_CYC),
      .o_ACK  (o_ACK),
      .o_SEL  (o_SEL)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   typedef struct {
      logic          is_read;
      logic [DW-1:0] exp;
   } sb_t;

   vec_t          vecs [10];
   sb_t           sb_q [$];
   int            n_total = 0;
   int            n_fail  = 0;
   int            cyc_cnt = 0;
   int            gnt_cnt = 0;
   logic [DW-1:0] held_rd = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
      end
   endfunction

   // Scoreboard: each o_gnt pulse consumes one expected o_rdata value.
   always @(negedge clk) begin
      if (o_gnt) begin
         sb_t e;
         gnt_cnt++;
         if (sb_q.size() == 0) begin
            check("spurious_gnt", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check(e.is_read ? "gnt_rdata" : "gnt_rdata_hold", o_rdata, e.exp);
         end
      end
   end

   task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
      @(negedge clk);
      i_req   = 1'b1;
      i_we    = we;
      i_addr  = addr;
      i_wdata = wdata;
      if (!we) held_rd = exp;
      sb_q.push_back('{is_read: !we, exp: held_rd});
      @(posedge clk); #1;
      check("E_handshake", {o_CYC, o_STB, o_ACK, o_gnt}, 4'b1100);
      check("E_we", o_WE, we);
      check("E_addr", o_ADDR, addr);
      check("E_sel", o_SEL, 4'hF);
      if (we) check("E_data", o_DATA, wdata);
      i_req   = 1'b0;
      i_we    = ~we;
      i_addr  = ~addr;
      i_wdata = ~wdata;
      @(posedge clk); #1;
      check("E1_handshake", {o_CYC, o_STB, o_ACK, o_gnt, o_WE}, {4'b1110, we});
      if (!we) check("E1_sdata", o_SDATA, exp);
      @(posedge clk); #1;
      check("E2_handshake", {o_CYC, o_STB, o_ACK, o_gnt, o_WE}, 5'b00010);
      check("E2_addr_hold", o_ADDR, addr);
      @(posedge clk); #1;
      check("E3_gnt_low", {o_CYC, o_ACK, o_gnt}, 3'b000);
   endtask

   initial begin
      int c0;
      int gcount;
      int gcyc [3];
      int gnt_before;

      vecs[0] = '{1'b1, 32'd0,      32'h1122_3344, 32'h0};
      vecs[1] = '{1'b1, 32'd1,      32'h5566_7788, 32'h0};
      vecs[2] = '{1'b0, 32'd0,      32'h0,         32'h1122_3344};
      vecs[3] = '{1'b0, 32'd1,      32'h0,         32'h5566_7788};
      vecs[4] = '{1'b0, MD + 1,     32'h0,         32'h5566_7788};
      vecs[5] = '{1'b1, 32'd15,     32'hDEAD_BEEF, 32'h0};
      vecs[6] = '{1'b0, 32'd31,     32'h0,         32'hDEAD_BEEF};
      vecs[7] = '{1'b1, 32'h12,     32'hA5A5_A5A5, 32'h0};
      vecs[8] = '{1'b0, 32'd2,      32'h0,         32'hA5A5_A5A5};
      vecs[9] = '{1'b0, 32'd0,      32'h0,         32'h1122_3344};

      rst = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", o_rdata, 0);
      check("rst_addr", o_ADDR, 0);
      check("rst_data", o_DATA, 0);
      check("rst_sdata", o_SDATA, 0);
      check("rst_ctrl", {o_WE, o_STB, o_CYC, o_ACK, o_gnt, o_SEL}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("idle_quiet", {o_CYC, o_STB, o_ACK}, 3'b000);
      end

      for (int w = 0; w < MD; w++) begin
         do_txn(1'b0, w, '0, '0);
      end

      for (int i = 0; i < 10; i++) begin
         do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      end

      // Request held high: transactions must run exactly 3 cycles apart.
      @(negedge clk);
      i_req  = 1'b1;
      i_we   = 1'b0;
      i_addr = 32'd1;
      held_rd = 32'h5566_7788;
      repeat (3) sb_q.push_back('{is_read: 1'b1, exp: held_rd});
      @(posedge clk); #1;
      c0 = cyc_cnt;
      gcount = 0;
      for (int i = 0; i < 30 && gcount < 3; i++) begin
         if (o_gnt) begin
            gcyc[gcount] = cyc_cnt;
            gcount++;
            if (gcount == 3) i_req = 1'b0;
         end
         if (gcount < 3) begin
            @(posedge clk); #1;
         end
      end
      check("b2b_count", gcount, 3);
      if (gcount == 3) begin
         check("b2b_latency", gcyc[0] - c0, 2);
         check("b2b_gap01", gcyc[1] - gcyc[0], 3);
         check("b2b_gap12", gcyc[2] - gcyc[1], 3);
      end
      @(posedge clk); #1;
      check("b2b_stop", {o_CYC, o_STB}, 2'b00);

      // Reset while a write to addr 2 is in flight.
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b1; i_addr = 32'd2; i_wdata = 32'h9999_9999;
      @(posedge clk); #1;
      i_req = 1'b0;
      check("abort_busy", {o_CYC, o_STB, o_ACK}, 3'b110);
      #1 rst = 1'b1;
      #1;
      check("abort_bus_drop", {o_CYC, o_STB, o_ACK, o_WE, o_gnt}, 5'b00000);
      check("abort_addr", o_ADDR, 0);
      gnt_before = gnt_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_gnt", gnt_cnt, gnt_before);
      held_rd = '0;
      do_txn(1'b0, 32'd2, '0, 32'h0);
      do_txn(1'b0, 32'd0, '0, 32'h0);

      repeat (2) @(posedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule

// File: doc/wishbone_master_slave.md
# wishbone_master_slave

Single-clock Wishbone B4 classic point-to-point subsystem: a request-driven Wishbone master bridging a simple req/gnt client port onto the bus, wired to a word-addressed register-file slave. The client issues single reads and writes; the master runs one bus cycle per request, and the slave stores and returns 32-bit words. The internal bus signals are also driven out as monitor outputs, so benches can check the handshake directly.

## Interface
Parameters:
- DATA_WIDTH, 32, bus and client data width; must be a multiple of 8.
- ADDR_WIDTH, 32, bus and client address width.
- MEM_DEPTH, 16, number of slave words; must be a power of 2.

Ports:
- i_CLK  in  1  single clock; all logic is on the rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_req  in  1  client request strobe; sampled only while the master is IDLE.
- i_addr  in  ADDR_WIDTH  client word address.
- i_wdata  in  DATA_WIDTH  client write data.
- i_we  in  1  1 = write, 0 = read.
- o_rdata  out  DATA_WIDTH  read data; valid while o_gnt=1 for a read, then held until the next read completes.
- o_gnt  out  1  one-cycle completion pulse.
- o_ADDR, o_DATA (master-to-slave), o_SDATA (slave-to-master)  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  bus monitor.
- o_WE, o_STB, o_CYC, o_ACK  out  1  bus monitor.
- o_SEL  out  DATA_WIDTH/8  bus monitor.

## Operation
Master FSM, states IDLE and BUSY:
- IDLE, i_req=1 at an edge:
  - latch i_addr, i_wdata and i_we onto ADDR, DATA and WE;
  - set SEL to all ones, CYC=1, STB=1;
  - go to BUSY.
- BUSY, at an edge where CYC&STB&ACK=1:
  - CYC=0, STB=0, WE=0;
  - o_gnt=1 for exactly one cycle;
  - on a read, capture the slave data into o_rdata;
  - go to IDLE.
- i_req is ignored while BUSY; no queuing.
- ADDR and DATA hold their values after the cycle ends.

Slave:
- ACK is registered: ACK <= CYC & STB & ~ACK. It is a one-cycle pulse per access, never back-to-back.
- On the edge that raises ACK:
  - write (WE=1): each byte lane with SEL[k]=1 is written to mem[ADDR mod MEM_DEPTH];
  - read (WE=0): slave data <= mem[ADDR mod MEM_DEPTH].
- Address bits above log2(MEM_DEPTH) are ignored, so addresses wrap.
- Slave data holds its value between reads.

Reset (asynchronous):
- Master returns to IDLE.
- CYC, STB, WE, SEL, ADDR, DATA, o_rdata and o_gnt all go to 0.
- Slave ACK, slave data and every mem word go to 0.
- Reset during BUSY aborts the cycle with no memory write and no o_gnt.

No tag, ERR, RTY or pipelined-mode signals.

## Timing
Take edge E as the edge where the master samples i_req=1 in IDLE.
- After E: CYC=STB=1 and the address, data and WE are stable.
- After E+1: ACK=1, and the write is committed or the read data is registered.
- After E+2: CYC=STB=ACK=0, o_gnt=1 and o_rdata is valid.
- After E+3: o_gnt=0, and the master can accept a new i_req.

Throughput and latency:
- Latency from request to o_gnt is 2 cycles.
- The minimum spacing between accepted requests is 3 cycles.

Boundary behaviour:
- If i_req is still high in the o_gnt cycle, a new transaction starts at the next edge.
- A one-cycle i_req pulse is sufficient.

## Test plan
- Reset: hold i_RST=1, then release it. Every output and every memory word reads 0; CYC, STB and ACK stay 0 while i_req=0.
- Write: one-cycle i_req with we=1, addr=0, wdata=0x11223344.
  - CYC/STB high for 2 cycles, SEL=0xF, ACK high for 1 cycle.
  - o_gnt pulses 2 cycles after the request.
  - mem[0]=0x11223344.
- Second write: addr=1, wdata=0x55667788. mem[1]=0x55667788 and mem[0] is unchanged.
- Read-back: read addr=0, then addr=1.
  - o_rdata is 0x11223344 in the first o_gnt cycle and 0x55667788 in the second.
  - WE=0 throughout, and memory is unchanged.
- Wrap and hold:
  - Read addr=MEM_DEPTH+1; returns 0x55667788.
  - Hold i_req high continuously; back-to-back transactions run exactly 3 cycles apart.
- Mid-cycle reset: assert i_RST while a write to addr=2 is BUSY. The bus drops immediately, there is no o_gnt, and mem[2]=0.
